expr_result_misr: RTL and testbench



---
 rtl/expr_cap_pkg.sv | 26 ++
 rtl/expr_misr_core.sv | 35 +++
 rtl/expr_result_misr.sv | 118 +++++++++++
 tb/tb_expr_result_misr.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/expr_cap_pkg.sv
// Shared types, constants and the XOR fold for the expression-result capture stage.
package expr_cap_pkg;

  localparam int SIG_W      = 32;
  localparam int FOLD_MAX_W = 128;

  localparam logic [SIG_W-1:0] POLY_DEFAULT = 32'h04C11DB7;
  localparam logic [SIG_W-1:0] SEED_DEFAULT = 32'h00000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_e;

  // Input is zero-extended to FOLD_MAX_W by the caller, so any DATA_W up to 128 folds correctly.
  function automatic logic [SIG_W-1:0] fold_chunks(input logic [FOLD_MAX_W-1:0] d);
    logic [SIG_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < FOLD_MAX_W / SIG_W; i++) begin
      acc = acc ^ d[i*SIG_W +: SIG_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/expr_misr_core.sv
// Signature register with shift/feedback/fold next-state logic.
module expr_misr_core
  import expr_cap_pkg::*;
#(
  parameter int               DATA_W = 90,
  parameter logic [SIG_W-1:0] POLY   = POLY_DEFAULT,
  parameter logic [SIG_W-1:0] SEED   = SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_seed,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] data,
  output logic [SIG_W-1:0]  sig,
  output logic [SIG_W-1:0]  sig_next
);

  logic [FOLD_MAX_W-1:0] data_ext;
  logic [SIG_W-1:0]      feedback;

  assign data_ext = FOLD_MAX_W'(data);
  assign feedback = sig[SIG_W-1] ? POLY : '0;
  assign sig_next = {sig[SIG_W-2:0], 1'b0} ^ feedback ^ fold_chunks(data_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (load_seed) begin
      sig <= SEED;
    end else if (shift_en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/expr_result_misr.sv
// Run-control FSM, vector counter and handshake around the MISR core.
// Optional golden compare enabled by defining EXPR_MISR_GOLDEN_EN.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting vectors into the signature
// DONE  | run complete, signature and count held
module expr_result_misr
  import expr_cap_pkg::*;
#(
  parameter int               DATA_W  = 90,
  parameter logic [SIG_W-1:0] POLY    = POLY_DEFAULT,
  parameter logic [SIG_W-1:0] SEED    = SEED_DEFAULT,
  parameter int               NUM_VEC = 256,
  parameter logic [SIG_W-1:0] GOLDEN  = 32'h00000000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_data,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NUM_VEC+1)-1:0]   vec_count,
  output logic [SIG_W-1:0]               signature,
  output logic                           pass
);

  localparam int CNT_W = $clog2(NUM_VEC + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);

  run_state_e       state, state_next;
  logic             accept;
  logic             last_accept;
  logic             load_seed;
  logic [SIG_W-1:0] sig_next;

  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (vec_count == LAST_IDX);
  assign load_seed   = start && (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_accept) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Handshake depends on state only, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Saturates at NUM_VEC because RUN is left on the accept that reaches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_count <= '0;
    end else if (load_seed) begin
      vec_count <= '0;
    end else if (accept) begin
      vec_count <= vec_count + CNT_W'(1);
    end
  end

  expr_misr_core #(
    .DATA_W (DATA_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_seed (load_seed),
    .shift_en  (accept),
    .data      (in_data),
    .sig       (signature),
    .sig_next  (sig_next)
  );

`ifdef EXPR_MISR_GOLDEN_EN
  // Compare the value being loaded on the DONE-entry edge, not the registered one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass <= 1'b0;
    end else if (load_seed) begin
      pass <= 1'b0;
    end else if (last_accept) begin
      pass <= (sig_next == GOLDEN);
    end
  end
`else
  logic unused_golden;
  assign unused_golden = ^{GOLDEN, sig_next};
  assign pass          = 1'b0;
`endif

endmodule

// File: tb/tb_expr_result_misr.sv
// Directed bench for expr_result_misr using several parameterised instances.
module tb_expr_result_misr;

`ifdef EXPR_MISR_GOLDEN_EN
  localparam logic GOLD_ON = 1'b1;
`else
  localparam logic GOLD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // A: NUM_VEC=4, SEED=0
  logic a_start, a_valid, a_ready, a_busy, a_done, a_pass;
  logic [89:0] a_data;
  logic [2:0]  a_cnt;
  logic [31:0] a_sig;
  // B: NUM_VEC=1, SEED=0, GOLDEN=1
  logic b_start, b_valid, b_ready, b_busy, b_done, b_pass;
  logic [89:0] b_data;
  logic [0:0]  b_cnt;
  logic [31:0] b_sig;
  // C/E: NUM_VEC=1, SEED=80000000, GOLDEN=04C11DB7 / 0, shared stimulus
  logic ce_start, ce_valid;
  logic [89:0] ce_data;
  logic c_ready, c_busy, c_done, c_pass, e_ready, e_busy, e_done, e_pass;
  logic [0:0]  c_cnt, e_cnt;
  logic [31:0] c_sig, e_sig;
  // D: NUM_VEC=3, SEED=0
  logic d_start, d_valid, d_ready, d_busy, d_done, d_pass;
  logic [89:0] d_data;
  logic [1:0]  d_cnt;
  logic [31:0] d_sig;

  expr_result_misr #(.NUM_VEC(4), .SEED(32'h0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .busy(a_busy), .done(a_done), .vec_count(a_cnt), .signature(a_sig), .pass(a_pass));
  expr_result_misr #(.NUM_VEC(1), .SEED(32'h0), .GOLDEN(32'h1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .busy(b_busy), .done(b_done), .vec_count(b_cnt), .signature(b_sig), .pass(b_pass));
  expr_result_misr #(.NUM_VEC(1), .SEED(32'h80000000), .GOLDEN(32'h04C11DB7)) u_c (
    .clk(clk), .rst_n(rst_n), .start(ce_start), .in_valid(ce_valid), .in_ready(c_ready),
    .in_data(ce_data), .busy(c_busy), .done(c_done), .vec_count(c_cnt), .signature(c_sig), .pass(c_pass));
  expr_result_misr #(.NUM_VEC(1), .SEED(32'h80000000), .GOLDEN(32'h0)) u_e (
    .clk(clk), .rst_n(rst_n), .start(ce_start), .in_valid(ce_valid), .in_ready(e_ready),
    .in_data(ce_data), .busy(e_busy), .done(e_done), .vec_count(e_cnt), .signature(e_sig), .pass(e_pass));
  expr_result_misr #(.NUM_VEC(3), .SEED(32'h0)) u_d (
    .clk(clk), .rst_n(rst_n), .start(d_start), .in_valid(d_valid), .in_ready(d_ready),
    .in_data(d_data), .busy(d_busy), .done(d_done), .vec_count(d_cnt), .signature(d_sig), .pass(d_pass));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    a_start = 0; a_valid = 0; a_data = '0;
    b_start = 0; b_valid = 0; b_data = '0;
    ce_start = 0; ce_valid = 0; ce_data = '0;
    d_start = 0; d_valid = 0; d_data = '0;
    #12 rst_n = 1'b1;

    // Idle with in_valid held, no start
    a_valid = 1'b1;
    repeat (3) tick();
    chk("idle_ready", 32'(a_ready), 32'd0);
    chk("idle_sig",   a_sig, 32'h0);
    chk("idle_cnt",   32'(a_cnt), 32'd0);
    chk("idle_done",  32'(a_done), 32'd0);
    chk("idle_pass",  32'(a_pass), 32'd0);

    // Zero stream, four back-to-back accepts
    a_start = 1'b1; tick(); a_start = 1'b0;
    chk("zs_busy",  32'(a_busy), 32'd1);
    chk("zs_ready", 32'(a_ready), 32'd1);
    repeat (3) tick();
    chk("zs_cnt3",  32'(a_cnt), 32'd3);
    chk("zs_done3", 32'(a_done), 32'd0);
    tick();
    chk("zs_done",  32'(a_done), 32'd1);
    chk("zs_busy0", 32'(a_busy), 32'd0);
    chk("zs_cnt",   32'(a_cnt), 32'd4);
    chk("zs_sig",   a_sig, 32'h0);
    chk("zs_rdy0",  32'(a_ready), 32'd0);
    a_valid = 1'b0;

    // Fold checks, NUM_VEC=1
    b_valid = 1'b1; b_data = 90'h1_00000000; b_start = 1'b1;
    tick(); b_start = 1'b0; tick();
    chk("fold32_done", 32'(b_done), 32'd1);
    chk("fold32_sig",  b_sig, 32'h00000001);
    chk("fold32_cnt",  32'(b_cnt), 32'd1);
    chk("fold32_pass", 32'(b_pass), 32'(GOLD_ON));
    b_data = 90'h1_00000000_00000000; b_start = 1'b1;
    tick(); b_start = 1'b0;
    chk("restart_done", 32'(b_done), 32'd0);
    chk("restart_sig",  b_sig, 32'h0);
    chk("restart_cnt",  32'(b_cnt), 32'd0);
    chk("restart_pass", 32'(b_pass), 32'd0);
    tick();
    chk("fold64_sig", b_sig, 32'h00000001);
    b_data = 90'h1_00000001; b_start = 1'b1;
    tick(); b_start = 1'b0; tick();
    chk("fold0_32_sig",  b_sig, 32'h00000000);
    chk("fold0_32_pass", 32'(b_pass), 32'd0);
    b_valid = 1'b0;

    // Feedback tap with golden match / mismatch
    ce_valid = 1'b1; ce_data = '0; ce_start = 1'b1;
    tick(); ce_start = 1'b0; tick();
    chk("fb_sig_c",  c_sig, 32'h04C11DB7);
    chk("fb_sig_e",  e_sig, 32'h04C11DB7);
    chk("fb_pass_c", 32'(c_pass), 32'(GOLD_ON));
    chk("fb_pass_e", 32'(e_pass), 32'd0);
    ce_valid = 1'b0;

    // Backpressure with a mid-run start, NUM_VEC=3
    d_start = 1'b1; tick(); d_start = 1'b0;
    d_valid = 1'b1; d_data = 90'h1; tick();
    d_valid = 1'b0; d_data = {90{1'b1}}; d_start = 1'b1; tick(); d_start = 1'b0;
    chk("bp_cnt1", 32'(d_cnt), 32'd1);
    chk("bp_sig1", d_sig, 32'h00000001);
    chk("bp_busy", 32'(d_busy), 32'd1);
    d_valid = 1'b1; d_data = 90'h0_80000000_00000000; tick();
    d_valid = 1'b0; d_data = {90{1'b1}}; tick();
    chk("bp_cnt2", 32'(d_cnt), 32'd2);
    chk("bp_sig2", d_sig, 32'h80000002);
    d_valid = 1'b1; d_data = 90'h2_00000000_00000008; tick();
    chk("bp_done", 32'(d_done), 32'd1);
    chk("bp_cnt3", 32'(d_cnt), 32'd3);
    chk("bp_sig3", d_sig, 32'h04C11DB9);
    repeat (2) tick();
    chk("bp_hold_cnt", 32'(d_cnt), 32'd3);
    chk("bp_hold_sig", d_sig, 32'h04C11DB9);
    d_valid = 1'b0; d_start = 1'b1; tick(); d_start = 1'b0;
    d_valid = 1'b1; d_data = 90'h1; tick();
    d_data = 90'h0_80000000_00000000; tick();
    d_data = 90'h2_00000000_00000008; tick();
    d_valid = 1'b0;
    chk("rerun_done", 32'(d_done), 32'd1);
    chk("rerun_sig",  d_sig, 32'h04C11DB9);

    // Reset mid-run after two vectors
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_valid = 1'b1; a_data = 90'h5; tick();
    a_data = 90'h7; tick();
    chk("mid_sig", a_sig, 32'h0000000D);
    chk("mid_cnt", 32'(a_cnt), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sig",   a_sig, 32'h0);
    chk("rst_cnt",   32'(a_cnt), 32'd0);
    chk("rst_busy",  32'(a_busy), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_done",  32'(a_done), 32'd0);
    chk("rst_d_done", 32'(d_done), 32'd0);
    chk("rst_c_pass", 32'(c_pass), 32'd0);
    a_valid = 1'b0;
    #10 rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(a_ready), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
